// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM port arbiter: FSM state encoding and requester ids.
package vram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RDACK,
    CLEAR
  } arb_state_t;

  typedef enum logic {
    REQ_CPU,
    REQ_GFX
  } req_id_t;

  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_CPU) ? REQ_GFX : REQ_CPU;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU / graphics request ports and the VRAM port, bundled for the arbiter.
interface vram_arbiter_if #(
  parameter int N = 32
);
  logic         cpu_req;
  logic         cpu_we;
  logic [N-1:0] cpu_addr;
  logic [N-1:0] cpu_wdata;
  logic         cpu_ack;
  logic [N-1:0] cpu_rdata;

  logic         gfx_req;
  logic [N-1:0] gfx_addr;
  logic [N-1:0] gfx_wdata;
  logic         gfx_ack;

  logic         vram_we;
  logic [N-1:0] vram_addr;
  logic [N-1:0] vram_wdata;
  logic [N-1:0] vram_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  gfx_req, gfx_addr, gfx_wdata,
    input  vram_rdata,
    output cpu_ack, cpu_rdata, gfx_ack,
    output vram_we, vram_addr, vram_wdata
  );

  // Requesters plus the VRAM, seen from outside the arbiter
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output gfx_req, gfx_addr, gfx_wdata,
    output vram_rdata,
    input  cpu_ack, cpu_rdata, gfx_ack,
    input  vram_we, vram_addr, vram_wdata
  );
endinterface

// File: rtl/vram_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie, the requester that did not win last time wins.
import vram_arb_pkg::*;

module rr_arb2 (
  input  logic    req_cpu,
  input  logic    req_gfx,
  input  req_id_t rr,
  input  logic    en,
  output req_id_t win,
  output logic    vld
);

  always_comb begin
    vld = en && (req_cpu || req_gfx);
    win = REQ_CPU;
    if (req_cpu && req_gfx) win = other_id(rr);
    else if (req_gfx)       win = REQ_GFX;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the VRAM port between CPU and graphics engine and runs a full-VRAM clear.
// Optional macro VRAM_ARB_VBLANK_GATE_EN: writes and clear entry only start during vblank.
import vram_arb_pkg::*;

module vram_arbiter #(
  parameter int N    = 32,
  parameter int SIZE = 10
) (
  input  logic          clk,
  input  logic          rst,
  vram_arbiter_if.slave bus,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          vblank,
  output logic          oob_err
);

  localparam logic [N-1:0] SIZE_W   = N'(SIZE);
  localparam logic [N-1:0] LAST_IDX = N'(SIZE - 1);

  arb_state_t   state_q, state_d;
  req_id_t      rr_q, rr_d;
  req_id_t      win_q, win_d;
  logic         clr_pending_q, clr_pending_d;
  logic [N-1:0] clr_idx_q, clr_idx_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         oob_q, oob_d;
  logic [N-1:0] cpu_rdata_q, cpu_rdata_d;
  logic         oob_err_q, oob_err_d;

  logic         wr_ok;
  logic         cpu_elig, gfx_elig, clr_go, arb_en, arb_vld;
  req_id_t      arb_win;

`ifdef VRAM_ARB_VBLANK_GATE_EN
  assign wr_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign wr_ok         = 1'b1;
`endif

  // Reads are never gated; writes and the start of a clear wait for wr_ok.
  assign cpu_elig = bus.cpu_req && (!bus.cpu_we || wr_ok);
  assign gfx_elig = bus.gfx_req && wr_ok;
  assign clr_go   = clr_pending_q && wr_ok;
  assign arb_en   = (state_q == IDLE) && !clr_go;

  rr_arb2 u_arb (
    .req_cpu (cpu_elig),
    .req_gfx (gfx_elig),
    .rr      (rr_q),
    .en      (arb_en),
    .win     (arb_win),
    .vld     (arb_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (clr_go)       state_d = CLEAR;
        else if (arb_vld) state_d = (arb_win == REQ_GFX || bus.cpu_we) ? WRITE : READ;
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = RDACK;
      RDACK:   state_d = IDLE;
      CLEAR:   if (clr_idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d          = rr_q;
    win_d         = win_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    oob_d         = oob_q;
    cpu_rdata_d   = cpu_rdata_q;
    oob_err_d     = oob_err_q;
    clr_idx_d     = clr_idx_q;
    clr_pending_d = clr_pending_q;

    if (clr_start && state_q != CLEAR) clr_pending_d = 1'b1;

    if (state_q == IDLE && arb_vld) begin
      rr_d    = arb_win;
      win_d   = arb_win;
      addr_d  = (arb_win == REQ_CPU) ? bus.cpu_addr  : bus.gfx_addr;
      wdata_d = (arb_win == REQ_CPU) ? bus.cpu_wdata : bus.gfx_wdata;
      oob_d   = (addr_d >= SIZE_W);
      if (oob_d) oob_err_d = 1'b1;
    end

    if (state_q == READ) cpu_rdata_d = oob_q ? '0 : bus.vram_rdata;

    if (state_q == CLEAR) begin
      if (clr_idx_q == LAST_IDX) begin
        clr_idx_d     = '0;
        clr_pending_d = 1'b0;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q          <= REQ_GFX;
      win_q         <= REQ_CPU;
      addr_q        <= '0;
      wdata_q       <= '0;
      oob_q         <= 1'b0;
      cpu_rdata_q   <= '0;
      oob_err_q     <= 1'b0;
      clr_idx_q     <= '0;
      clr_pending_q <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      win_q         <= win_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      oob_q         <= oob_d;
      cpu_rdata_q   <= cpu_rdata_d;
      oob_err_q     <= oob_err_d;
      clr_idx_q     <= clr_idx_d;
      clr_pending_q <= clr_pending_d;
    end
  end

  // Port outputs come from registered state only; nothing from req reaches vram_*.
  always_comb begin
    bus.vram_we    = 1'b0;
    bus.vram_addr  = '0;
    bus.vram_wdata = '0;
    bus.cpu_ack    = 1'b0;
    bus.gfx_ack    = 1'b0;
    unique case (state_q)
      WRITE: begin
        bus.vram_we    = !oob_q;
        bus.vram_addr  = addr_q;
        bus.vram_wdata = wdata_q;
        bus.cpu_ack    = (win_q == REQ_CPU);
        bus.gfx_ack    = (win_q == REQ_GFX);
      end
      READ:  bus.vram_addr = addr_q;
      RDACK: bus.cpu_ack   = 1'b1;
      CLEAR: begin
        bus.vram_we   = 1'b1;
        bus.vram_addr = clr_idx_q;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign clr_busy      = clr_pending_q || (state_q == CLEAR);
  assign oob_err       = oob_err_q;

endmodule
